// File: rtl/braille_cell_driver.sv
// Small synchronous FIFO with power-of-two depth and a registered occupancy count.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: a push while full or a pop while empty is ignored; the caller gates on full/empty.
module braille_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_rdy & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Queues ASCII letters and drives each as a 6-dot Braille cell for HOLD_CYCLES, then blanks for GAP_CYCLES.
// Latency: a character strobed into an idle, empty driver is on the dots one cycle after it is sampled.
// Backpressure: none upstream; characters arriving while the queue is full are dropped and flagged on o_drop.
module braille_cell_driver #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_alpha,
    output logic [5:0] o_dots,
    output logic       o_dots_valid,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_drop,
    output logic       o_err
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_upper;
    logic          is_lower;
    logic          is_space;
    logic          supported;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_rdy;
    logic [7:0]    head_dat;

    assign is_upper  = (i_alpha >= 8'h41) && (i_alpha <= 8'h5A);
    assign is_lower  = (i_alpha >= 8'h61) && (i_alpha <= 8'h7A);
    assign is_space  = (i_alpha == 8'h20);
    assign supported = is_upper | is_lower | is_space;
    assign pop_rdy   = (state == IDLE) & ~fifo_empty;

    // Raw codes are queued; case folding and the dot lookup happen on dequeue.
    function automatic logic [5:0] dot_pattern(input logic [7:0] c);
        logic [7:0] lc;
        lc = c | 8'h20;
        case (lc)
            8'h61: dot_pattern = 6'h01;  8'h62: dot_pattern = 6'h03;
            8'h63: dot_pattern = 6'h09;  8'h64: dot_pattern = 6'h19;
            8'h65: dot_pattern = 6'h11;  8'h66: dot_pattern = 6'h0B;
            8'h67: dot_pattern = 6'h1B;  8'h68: dot_pattern = 6'h13;
            8'h69: dot_pattern = 6'h0A;  8'h6A: dot_pattern = 6'h1A;
            8'h6B: dot_pattern = 6'h05;  8'h6C: dot_pattern = 6'h07;
            8'h6D: dot_pattern = 6'h0D;  8'h6E: dot_pattern = 6'h1D;
            8'h6F: dot_pattern = 6'h15;  8'h70: dot_pattern = 6'h0F;
            8'h71: dot_pattern = 6'h1F;  8'h72: dot_pattern = 6'h17;
            8'h73: dot_pattern = 6'h0E;  8'h74: dot_pattern = 6'h1E;
            8'h75: dot_pattern = 6'h25;  8'h76: dot_pattern = 6'h27;
            8'h77: dot_pattern = 6'h3A;  8'h78: dot_pattern = 6'h2D;
            8'h79: dot_pattern = 6'h3D;  8'h7A: dot_pattern = 6'h35;
            default: dot_pattern = 6'h00;
        endcase
    endfunction

    braille_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (i_valid & supported),
        .push_dat (i_alpha),
        .pop_rdy  (pop_rdy),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign o_full = fifo_full;
    assign o_busy = (state != IDLE) | ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_dots       <= '0;
            o_dots_valid <= 1'b0;
            o_drop       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_drop <= i_valid & supported & fifo_full;
            o_err  <= i_valid & ~supported;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        o_dots       <= dot_pattern(head_dat);
                        o_dots_valid <= 1'b1;
                        cnt          <= HOLD_LOAD;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        o_dots       <= '0;
                        o_dots_valid <= 1'b0;
                        cnt          <= GAP_LOAD;
                        state        <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_braille_cell_driver.sv
// Directed bench: short-timing instance for queueing/error/reset cases, default-timing instance for hold/gap length.
module tb_braille_cell_driver;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       i_valid;
    logic [7:0] i_alpha;
    logic [5:0] o_dots;
    logic       o_dots_valid, o_busy, o_full, o_drop, o_err;

    logic       d_valid;
    logic [7:0] d_alpha;
    logic [5:0] d_dots;
    logic       d_dots_valid, d_busy, d_full, d_drop, d_err;

    braille_cell_driver #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_alpha(i_alpha),
        .o_dots(o_dots), .o_dots_valid(o_dots_valid), .o_busy(o_busy),
        .o_full(o_full), .o_drop(o_drop), .o_err(o_err)
    );

    braille_cell_driver dut_def (
        .clk(clk), .reset_n(reset_n), .i_valid(d_valid), .i_alpha(d_alpha),
        .o_dots(d_dots), .o_dots_valid(d_dots_valid), .o_busy(d_busy),
        .o_full(d_full), .o_drop(d_drop), .o_err(d_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cell log: each completed cell's pattern and hold length, and the blank run preceding it.
    logic [5:0] pat_q[$];
    int         len_q[$];
    int         gap_q[$];
    int         drop_cnt = 0, err_cnt = 0, full_cnt = 0, v_cnt = 0, bad_dots = 0;
    int         run_len = 0, low_len = 0;
    logic       prev_v = 1'b0;
    logic [5:0] cur_pat = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v  = 1'b0;
            low_len = 0;
        end else begin
            drop_cnt += int'(o_drop);
            err_cnt  += int'(o_err);
            full_cnt += int'(o_full);
            v_cnt    += int'(o_dots_valid);
            if (o_dots_valid) begin
                if (!prev_v) begin
                    gap_q.push_back(low_len);
                    cur_pat = o_dots;
                    run_len = 0;
                end
                if (o_dots !== cur_pat) bad_dots++;
                run_len++;
            end else begin
                if (prev_v) begin
                    pat_q.push_back(cur_pat);
                    len_q.push_back(run_len);
                    low_len = 0;
                end
                if (o_dots !== 6'h00) bad_dots++;
                low_len++;
            end
            prev_v = o_dots_valid;
        end
    end

    int pbase, gbase, drop_b, err_b, full_b, v_b;

    task automatic mark_log();
        pbase  = pat_q.size();
        gbase  = gap_q.size();
        drop_b = drop_cnt;
        err_b  = err_cnt;
        full_b = full_cnt;
        v_b    = v_cnt;
    endtask

    task automatic check_cell(input string tag, input int idx, input logic [5:0] pat, input int len);
        if (pbase + idx < pat_q.size()) begin
            chk({tag, "_pat"}, 32'(pat_q[pbase+idx]), 32'(pat));
            chk({tag, "_len"}, 32'(len_q[pbase+idx]), 32'(len));
        end else begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_gap(input string tag, input int idx, input int exp);
        if (gbase + idx < gap_q.size()) chk(tag, 32'(gap_q[gbase+idx]), 32'(exp));
        else                            chk({tag, "_missing"}, 32'd0, 32'd1);
    endtask

    task automatic strobe(input logic [7:0] c);
        i_valid = 1'b1;
        i_alpha = c;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, 32'(n >= 300), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dots"},  32'(o_dots), 32'd0);
        chk({tag, "_vld"},   32'(o_dots_valid), 32'd0);
        chk({tag, "_busy"},  32'(o_busy), 32'd0);
        chk({tag, "_full"},  32'(o_full), 32'd0);
        chk({tag, "_drop"},  32'(o_drop), 32'd0);
        chk({tag, "_err"},   32'(o_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, hold, gap, bad;
        reset_n = 1'b0; i_valid = 1'b0; i_alpha = '0; d_valid = 1'b0; d_alpha = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single 'a'
        mark_log();
        strobe(8'h61);
        chk("t1_vld_k", 32'(o_dots_valid), 32'd0);
        chk("t1_busy_k", 32'(o_busy), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("t1_vld_k1", 32'(o_dots_valid), 32'd1);
                chk("t1_dots_k1", 32'(o_dots), 32'h01);
            end
            if (i == 4) chk("t1_vld_k4", 32'(o_dots_valid), 32'd1);
            if (i == 5) chk("t1_vld_k5", 32'(o_dots_valid), 32'd0);
            if (i == 6) chk("t1_busy_k6", 32'(o_busy), 32'd1);
            if (i == 7) chk("t1_busy_k7", 32'(o_busy), 32'd0);
        end
        check_cell("t1_a", 0, 6'h01, HOLD);

        // 2: 'Z' then ' ' back-to-back
        mark_log();
        strobe(8'h5A);
        strobe(8'h20);
        wait_idle("t2");
        check_cell("t2_Z", 0, 6'h35, HOLD);
        check_cell("t2_sp", 1, 6'h00, HOLD);
        check_gap("t2_gap", 1, GAP + 1);

        // 3: "helloo" overfills the queue by one
        mark_log();
        strobe(8'h68); strobe(8'h65); strobe(8'h6C); strobe(8'h6C); strobe(8'h6F);
        chk("t3_full_at4", 32'(o_full), 32'd1);
        strobe(8'h6F);
        chk("t3_drop_pulse", 32'(o_drop), 32'd1);
        wait_idle("t3");
        check_cell("t3_h", 0, 6'h13, HOLD);
        check_cell("t3_e", 1, 6'h11, HOLD);
        check_cell("t3_l1", 2, 6'h07, HOLD);
        check_cell("t3_l2", 3, 6'h07, HOLD);
        check_cell("t3_o", 4, 6'h15, HOLD);
        chk("t3_ncells", 32'(pat_q.size() - pbase), 32'd5);
        chk("t3_drops", 32'(drop_cnt - drop_b), 32'd1);
        chk("t3_full_cycles", 32'(full_cnt - full_b), 32'd4);
        chk("t3_errs", 32'(err_cnt - err_b), 32'd0);
        check_gap("t3_gap", 4, GAP + 1);

        // 4: unsupported codes, including the edges of each letter range
        mark_log();
        strobe(8'h31); chk("t4_err_1", 32'(o_err), 32'd1);
        strobe(8'h40); chk("t4_err_at", 32'(o_err), 32'd1);
        strobe(8'h5B); chk("t4_err_lbr", 32'(o_err), 32'd1);
        strobe(8'h60); chk("t4_err_tick", 32'(o_err), 32'd1);
        strobe(8'h7B); chk("t4_err_lcb", 32'(o_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_errs", 32'(err_cnt - err_b), 32'd5);
        chk("t4_drops", 32'(drop_cnt - drop_b), 32'd0);
        chk("t4_busy", 32'(o_busy), 32'd0);
        chk("t4_vld_cycles", 32'(v_cnt - v_b), 32'd0);

        // 5: reset in the second hold cycle of 'q' with two more queued
        strobe(8'h71); strobe(8'h78); strobe(8'h79);
        chk("t5_pre_dots", 32'(o_dots), 32'h1F);
        chk("t5_pre_busy", 32'(o_busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("t5_rst");
        reset_n = 1'b1;
        @(negedge clk);
        mark_log();
        repeat (20) @(negedge clk);
        chk("t5_no_cell", 32'(v_cnt - v_b), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd0);

        // Letter-range endpoints 'A' and 'z'
        mark_log();
        strobe(8'h41);
        strobe(8'h7A);
        wait_idle("t5b");
        check_cell("t5b_A", 0, 6'h01, HOLD);
        check_cell("t5b_z", 1, 6'h35, HOLD);
        chk("t5b_bad_dots", 32'(bad_dots), 32'd0);

        // 6: default timing, 'k' then 'b'
        d_valid = 1'b1; d_alpha = 8'h6B;
        @(negedge clk);
        d_alpha = 8'h62;
        @(negedge clk);
        d_valid = 1'b0;
        chk("t6_busy", 32'(d_busy), 32'd1);
        chk("t6_start", 32'(d_dots_valid), 32'd1);
        hold = 0; bad = 0;
        while (d_dots_valid && hold < 1100) begin
            if (d_dots !== 6'h05) bad++;
            hold++;
            @(negedge clk);
        end
        chk("t6_hold", 32'(hold), 32'd1000);
        chk("t6_k_pat", 32'(bad), 32'd0);
        gap = 0;
        while (!d_dots_valid && gap < 300) begin
            gap++;
            @(negedge clk);
        end
        chk("t6_gap", 32'(gap), 32'd201);
        chk("t6_b_pat", 32'(d_dots), 32'h03);
        n = 0;
        while (d_busy && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk("t6_idle_timeout", 32'(n >= 1500), 32'd0);
        chk("t6_full", 32'(d_full), 32'd0);
        chk("t6_drop", 32'(d_drop), 32'd0);
        chk("t6_err", 32'(d_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
